segment_decoder: RTL and testbench
==================================

# segment_decoder

Receive-side counterpart of the team's 2-bit seven-segment encoder. It samples an 8-bit active-low segment bus, accepts a pattern only after it has held stable for a programmable number of cycles, and decodes it back to a 2-bit digit with a decimal-point flag. It also reports blank and illegal patterns. It sits on the display-monitor path, wherever a driven segment bus must be checked or read back as a number.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
- clk  input  1  system clock; every register updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- hexIn  input  8  segment bus, active-low. Bit 7 is the DP segment; bits 6:0 are segments g..a.
- numOut  output  2  last accepted digit.
- valid  output  1  high while the last accepted pattern is a legal digit.
- blank  output  1  high while the last accepted pattern has all segments off.
- dpOut  output  1  DP state of the last accepted digit; 1 means DP lit.
- changed  output  1  one-cycle pulse when a new digit or DP value is accepted.
- errPulse  output  1  one-cycle pulse when an illegal pattern is accepted.
- errCount  output  8  count of accepted illegal patterns; saturates at 255.

## Operation
- Legal codes on hexIn[6:0]:
  - 7'h40 decodes to 0.
  - 7'h79 decodes to 1.
  - 7'h24 decodes to 2.
  - 7'h30 decodes to 3.
  - 7'h7F decodes to blank.
  - Every other value is illegal.
- Decoding uses bits 6:0 only; hexIn[7] affects only dpOut.
- Sample register hexQ (8 bits) captures hexIn on every edge.
- Run counter cnt counts consecutive identical samples:
  - If hexIn != hexQ, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at STABLE_CYCLES.
- The accept event is true when hexIn == hexQ and cnt == STABLE_CYCLES-1. It fires exactly once per stable run.
- FSM states: BLANK (reset state), DIGIT, FAULT. On an accept event:
  - Legal digit: go to DIGIT. numOut <= digit, dpOut <= ~hexIn[7], valid <= 1, blank <= 0. Pulse changed if the previous state was not DIGIT, or if numOut or dpOut differ from the new values.
  - Blank: go to BLANK. valid <= 0, blank <= 1, dpOut <= 0. numOut holds its value. No changed pulse.
  - Illegal: go to FAULT. valid <= 0, blank <= 0. Pulse errPulse and increment errCount, saturating at 255. numOut and dpOut hold.
- With no accept event, the state and all level outputs hold. changed and errPulse are low.
- A pattern that holds for fewer than STABLE_CYCLES samples (a glitch) has no effect.
- A pattern identical to the one already accepted is re-accepted only after hexIn changes and returns. Re-accepting the same digit does not pulse changed. Re-accepting an illegal pattern pulses errPulse again.

## Timing
- Reset values (on any rising edge with rst_n=0):
  - hexQ = 8'hFF, cnt = 0, state = BLANK.
  - numOut = 0, valid = 0, blank = 1, dpOut = 0.
  - changed = 0, errPulse = 0, errCount = 0.
- Reset asserted mid-run discards the partial run. After release, the first sample restarts counting.
- Latency: if hexIn takes a new value just before edge E0, the accept event and all output updates occur at edge E0+STABLE_CYCLES-1. With STABLE_CYCLES=4, outputs change at E0+3.
- If hexIn changes at edge E0+k, with k < STABLE_CYCLES-1, the run restarts and cnt = 1 at that edge.
- changed and errPulse are registered and last exactly one cycle. They never assert together.
- errCount at 255 stays at 255; errPulse still fires.
- All outputs are registered. There is no combinational path from hexIn to any output.

## Test plan
- Reset check: hold rst_n=0 for 2 cycles with hexIn=8'h00 -> numOut=0, valid=0, blank=1, errCount=0. Release rst_n.
- Digit decode and latency: drive 8'hB0 from edge E0 with STABLE_CYCLES=4 -> at E0+3, numOut=3, valid=1, dpOut=0, and changed pulses for one cycle. Then drive 8'h30 -> dpOut=1 and changed pulses; numOut stays 3.
- Glitch rejection: while 3 is accepted, drive 8'hF9 for 3 cycles, then return to 8'hB0 -> no output change, no pulse. Then hold 8'hF9 for 4 cycles -> numOut=1 and changed pulses.
- Blank and re-entry: drive 8'hFF stable -> blank=1, valid=0, no changed pulse. Then drive 8'hC0 -> numOut=0, valid=1, and changed pulses.
- Illegal pattern: drive 8'h12 stable for 10 cycles -> exactly one errPulse, errCount=1, valid=0, blank=0. Alternate 8'h12 and 8'h13, each held 4 cycles, 300 times -> errCount saturates at 255.
- Mid-run reset: after 2 stable cycles of 8'hA4, assert rst_n=0 for 1 cycle and keep 8'hA4 driven -> outputs return to reset values, and numOut=2 is accepted 4 edges after reset release.

Source files
------------

// File: rtl/segment_decoder.sv
// Debounced receive-side decoder for the 2-bit active-low seven-segment bus.
// A pattern is acted on once it has been sampled STABLE_CYCLES times in a row.
module segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hexIn,
  output logic [1:0] numOut,
  output logic       valid,
  output logic       blank,
  output logic       dpOut,
  output logic       changed,
  output logic       errPulse,
  output logic [7:0] errCount
);

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_DIGIT,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    PAT_DIGIT,
    PAT_BLANK,
    PAT_ILLEGAL
  } pat_t;

  localparam logic [7:0] CNT_SAT    = 8'(STABLE_CYCLES);
  localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] ERR_MAX    = 8'hFF;

  function automatic pat_t classify(input logic [6:0] seg);
    pat_t kind;
    case (seg)
      7'h40, 7'h79, 7'h24, 7'h30: kind = PAT_DIGIT;
      7'h7F:                      kind = PAT_BLANK;
      default:                    kind = PAT_ILLEGAL;
    endcase
    return kind;
  endfunction

  function automatic logic [1:0] digit_of(input logic [6:0] seg);
    logic [1:0] d;
    case (seg)
      7'h79:   d = 2'd1;
      7'h24:   d = 2'd2;
      7'h30:   d = 2'd3;
      default: d = 2'd0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  logic [7:0] hex_q, hex_d;
  logic [7:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic [1:0] num_q, num_d;
  logic       valid_q, valid_d;
  logic       blank_q, blank_d;
  logic       dp_q, dp_d;
  logic       changed_q, changed_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       same_sample;
  logic       accept;
  pat_t       pat_kind;
  logic [1:0] pat_digit;
  logic       pat_dp;

  // Stability tracking: the accept strobe fires once, on the edge that
  // completes a run of STABLE_CYCLES identical samples.
  always_comb begin
    same_sample = (hexIn == hex_q);
    accept      = same_sample && (cnt_q == ACCEPT_CNT);
    hex_d       = hexIn;
    cnt_d       = same_sample ? sat_inc(cnt_q, CNT_SAT) : 8'd1;
    pat_kind    = classify(hexIn[6:0]);
    pat_digit   = digit_of(hexIn[6:0]);
    pat_dp      = ~hexIn[7];
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    valid_d     = valid_q;
    blank_d     = blank_q;
    dp_d        = dp_q;
    changed_d   = 1'b0;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      case (pat_kind)
        PAT_DIGIT: begin
          state_d   = ST_DIGIT;
          num_d     = pat_digit;
          dp_d      = pat_dp;
          valid_d   = 1'b1;
          blank_d   = 1'b0;
          changed_d = (state_q != ST_DIGIT) || (num_q != pat_digit) || (dp_q != pat_dp);
        end
        PAT_BLANK: begin
          state_d = ST_BLANK;
          valid_d = 1'b0;
          blank_d = 1'b1;
          dp_d    = 1'b0;
        end
        default: begin
          state_d     = ST_FAULT;
          valid_d     = 1'b0;
          blank_d     = 1'b0;
          err_pulse_d = 1'b1;
          err_cnt_d   = sat_inc(err_cnt_q, ERR_MAX);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_q       <= 8'hFF;
      cnt_q       <= 8'd0;
      state_q     <= ST_BLANK;
      num_q       <= 2'd0;
      valid_q     <= 1'b0;
      blank_q     <= 1'b1;
      dp_q        <= 1'b0;
      changed_q   <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      hex_q       <= hex_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      num_q       <= num_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      dp_q        <= dp_d;
      changed_q   <= changed_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign numOut   = num_q;
  assign valid    = valid_q;
  assign blank    = blank_q;
  assign dpOut    = dp_q;
  assign changed  = changed_q;
  assign errPulse = err_pulse_q;
  assign errCount = err_cnt_q;

endmodule

// File: tb/tb_segment_decoder.sv
// Randomised and directed bench for segment_decoder with a run-length reference model.
module tb_segment_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] hexIn;
  logic [1:0] numOut;
  logic       valid, blank, dpOut, changed, errPulse;
  logic [7:0] errCount;

  int n_checks = 0;
  int n_fail   = 0;

  segment_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .hexIn(hexIn), .numOut(numOut), .valid(valid),
    .blank(blank), .dpOut(dpOut), .changed(changed), .errPulse(errPulse),
    .errCount(errCount)
  );

  always #5 clk = ~clk;

  // Reference model: unbounded run length of the input; a pattern is taken
  // when its run reaches exactly STABLE samples.
  logic [6:0] codes [4] = '{7'h40, 7'h79, 7'h24, 7'h30};
  logic [7:0] m_prev;
  int         m_run;
  int         m_num;
  logic       m_valid, m_blank, m_dp, m_chg, m_err;
  int         m_cnt;
  bit         m_live = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev = 8'hFF; m_run = 0; m_num = 0; m_valid = 0; m_blank = 1;
      m_dp = 0; m_chg = 0; m_err = 0; m_cnt = 0;
    end else begin
      int idx;
      m_chg = 0;
      m_err = 0;
      m_run = (hexIn == m_prev) ? m_run + 1 : 1;
      m_prev = hexIn;
      if (m_run == STABLE) begin
        idx = -1;
        for (int i = 0; i < 4; i++) if (codes[i] == hexIn[6:0]) idx = i;
        if (idx >= 0) begin
          m_chg   = !m_valid || (m_num != idx) || (m_dp != !hexIn[7]);
          m_num   = idx;
          m_dp    = !hexIn[7];
          m_valid = 1;
          m_blank = 0;
        end else if (hexIn[6:0] == 7'h7F) begin
          m_valid = 0; m_blank = 1; m_dp = 0;
        end else begin
          m_valid = 0; m_blank = 0; m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [14:0] act, exp;
      act = {numOut, valid, blank, dpOut, changed, errPulse, errCount};
      exp = {m_num[1:0], m_valid, m_blank, m_dp, m_chg, m_err, m_cnt[7:0]};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, act, exp);
      end
      if (changed === 1'b1 && errPulse === 1'b1) begin
        n_fail++;
        $display("FAIL pulse_overlap t=%0t got both pulses high, expected at most one", $time);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    hexIn = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    logic [7:0] pool [7] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hFF, 8'h12, 8'h55};
    rst_n = 1'b0;
    hexIn = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_num", numOut, 0);
    chk("rst_valid", valid, 0);
    chk("rst_blank", blank, 1);
    chk("rst_errcnt", errCount, 0);

    rst_n = 1'b1;
    hold(8'hB0, 3);
    chk("lat_not_yet", valid, 0);
    hold(8'hB0, 1);
    chk("lat_num", numOut, 3);
    chk("lat_valid", valid, 1);
    chk("lat_dp", dpOut, 0);
    chk("lat_changed", changed, 1);
    hold(8'hB0, 1);
    chk("changed_one_cycle", changed, 0);
    hold(8'h30, 4);
    chk("dp_on", dpOut, 1);
    chk("dp_changed", changed, 1);
    chk("dp_num_hold", numOut, 3);

    hold(8'hB0, 4);
    chk("dp_off", dpOut, 0);
    hold(8'hF9, 3);
    hold(8'hB0, 5);
    chk("glitch_num", numOut, 3);
    chk("glitch_nochg", changed, 0);
    hold(8'hF9, 4);
    chk("one_num", numOut, 1);
    chk("one_changed", changed, 1);

    hold(8'hFF, 4);
    chk("blank_blank", blank, 1);
    chk("blank_valid", valid, 0);
    chk("blank_nochg", changed, 0);
    chk("blank_num_hold", numOut, 1);
    hold(8'hC0, 4);
    chk("zero_num", numOut, 0);
    chk("zero_valid", valid, 1);
    chk("zero_changed", changed, 1);

    hexIn = 8'h12;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (errPulse) pulses++;
    end
    chk("illegal_pulses", pulses, 1);
    chk("illegal_count", errCount, 1);
    chk("illegal_valid", valid, 0);
    chk("illegal_blank", blank, 0);
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 8'h13 : 8'h12, 4);
    chk("errcnt_sat", errCount, 255);
    chk("errpulse_at_sat", errPulse, 1);

    hold(8'hA4, 2);
    rst_n = 1'b0;
    hold(8'hA4, 1);
    chk("midrst_num", numOut, 0);
    chk("midrst_blank", blank, 1);
    chk("midrst_errcnt", errCount, 0);
    rst_n = 1'b1;
    hold(8'hA4, 3);
    chk("midrst_not_yet", valid, 0);
    hold(8'hA4, 1);
    chk("midrst_num2", numOut, 2);
    chk("midrst_changed", changed, 1);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 1) v[7] = ~v[7];
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        hold(v, $urandom_range(1, 2));
        rst_n = 1'b1;
      end
      hold(v, $urandom_range(1, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
